// File: rtl/seq_divider_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_divider_pkg                                                 |
// | Purpose  : Shared definitions for the arithmetic-lab sequential blocks:    |
// |            FSM state encoding (IDLE/CALC/FIN, 2 bits) and the step-counter |
// |            width helper.                                                   |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Bits needed to count 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_divider_if                                                  |
// | Purpose  : start/done handshake and operand/result bundle for the          |
// |            sequential divider.                                             |
// | Ports    : master - drives start, dividend, divisor; reads results         |
// |            slave  - the divider side                                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface seq_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : div_step                                                        |
// | Purpose  : One restoring-division step: shift the next dividend bit into   |
// |            the partial remainder, compare with the divisor, subtract when  |
// |            it fits.                                                        |
// | Ports    : rem_in   in  WIDTH  partial remainder (always < divisor)        |
// |            bit_in   in  1      next dividend bit, MSB first                |
// |            divisor  in  WIDTH  denominator                                 |
// |            rem_out  out WIDTH  new partial remainder                       |
// |            qbit     out 1      quotient bit produced by this step          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module div_step #(
    parameter int WIDTH = 4
) (
    input  wire logic [WIDTH-1:0] rem_in,
    input  wire logic             bit_in,
    input  wire logic [WIDTH-1:0] divisor,
    output logic      [WIDTH-1:0] rem_out,
    output logic                  qbit
);
    // The shifted remainder needs one extra bit, since rem_in < divisor
    // only guarantees the shifted value is < 2*divisor.
    logic [WIDTH:0] shifted;

    always_comb begin
        shifted = {rem_in, bit_in};
        qbit    = (shifted >= {1'b0, divisor});
        // When the subtract happens the result is < divisor, so the low
        // WIDTH bits of the modular difference are exact.
        rem_out = qbit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
    end
endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_divider                                                     |
// | Purpose  : Multi-cycle restoring divider, one quotient bit per clock.      |
// |            Unsigned by default; define SEQ_DIV_SIGNED_EN for two's         |
// |            complement operands (magnitude core + sign fix-up in FIN).      |
// | Ports    : clk  in  rising-edge clock                                      |
// |            rst  in  synchronous reset, active-high                         |
// |            bus  seq_divider_if.slave: start, dividend, divisor in;         |
// |                 quotient, remainder, busy, done, div_by_zero out           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    seq_divider_if.slave  bus
);
    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic             accept;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd_sh;   // dividend shifts out MSB first, quotient bits shift in
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic             dz_pend;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

`ifdef SEQ_DIV_SIGNED_EN
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] r_base;

    always_comb begin
        dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
        dvs_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
        // With a zero divisor no step ran, so dvd_sh still holds |dividend|
        // and negating it by the dividend sign restores the original value.
        r_base  = dz_pend ? dvd_sh : rem;
        r_fin   = neg_a ? -r_base : r_base;
        q_fin   = dz_pend ? '1 : ((neg_a ^ neg_b) ? -dvd_sh : dvd_sh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_a <= 1'b0;
            neg_b <= 1'b0;
        end else if (accept) begin
            neg_a <= bus.dividend[WIDTH-1];
            neg_b <= bus.divisor[WIDTH-1];
        end
    end
`else
    always_comb begin
        dvd_mag = bus.dividend;
        dvs_mag = bus.divisor;
        q_fin   = dz_pend ? '1 : dvd_sh;
        r_fin   = dz_pend ? dvd_sh : rem;
    end
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in  (rem),
        .bit_in  (dvd_sh[WIDTH-1]),
        .divisor (dvs),
        .rem_out (step_rem),
        .qbit    (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = (bus.divisor == '0) ? FIN : CALC;
                end
            end
            CALC: begin
                if (cnt == LAST) begin
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs. done lands in the cycle after FIN,
    // which is an IDLE cycle, so a held start is accepted right then.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt             <= '0;
            dvd_sh          <= '0;
            dvs             <= '0;
            rem             <= '0;
            dz_pend         <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvd_sh          <= dvd_mag;
                        dvs             <= dvs_mag;
                        rem             <= '0;
                        cnt             <= '0;
                        dz_pend         <= (bus.divisor == '0);
                        bus.div_by_zero <= 1'b0;
                        bus.busy        <= 1'b1;
                    end else begin
                        bus.busy        <= 1'b0;
                    end
                end
                CALC: begin
                    rem    <= step_rem;
                    dvd_sh <= {dvd_sh[WIDTH-2:0], step_q};
                    cnt    <= cnt + 1'b1;
                end
                FIN: begin
                    bus.quotient    <= q_fin;
                    bus.remainder   <= r_fin;
                    bus.div_by_zero <= dz_pend;
                    bus.done        <= 1'b1;
                    bus.busy        <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seq_divider                                                  |
// | Purpose  : Scoreboard bench for seq_divider (WIDTH=4). Directed vectors    |
// |            push expected results; a monitor pops them on every done.       |
// |            Signed vectors are used when SEQ_DIV_SIGNED_EN is defined.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_seq_divider;
    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient",    32'(bus.quotient),    32'(e.q));
                chk("remainder",   32'(bus.remainder),   32'(e.r));
                chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
                chk("busy_at_done", 32'(bus.busy),       32'd1);
            end
        end
    end

    // Called at the negedge following the accept edge N (k0 edges already
    // elapsed since N); returns at the negedge where done is high.
    task automatic wait_done(input int k0, input int exp_lat, input string name);
        int k;
        k = k0;
        while (bus.done !== 1'b1 && k < 40) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        chk(name, 32'(k), 32'(exp_lat));
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        sb.push_back('{q: q, r: r, dz: dz});
        issue(a, b);
        wait_done(0, (b == 0) ? 1 : W + 1, "latency");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_quotient",  32'(bus.quotient),    32'd0);
        chk("rst_remainder", 32'(bus.remainder),   32'd0);
        chk("rst_busy",      32'(bus.busy),        32'd0);
        chk("rst_done",      32'(bus.done),        32'd0);
        chk("rst_dz",        32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;

`ifdef SEQ_DIV_SIGNED_EN
        run_op(4'd9,  4'd2,  4'd13, 4'd15, 1'b0);   // -7 / 2  -> -3 r -1
        run_op(4'd7,  4'd14, 4'd13, 4'd1,  1'b0);   //  7 / -2 -> -3 r 1
        run_op(4'd8,  4'd15, 4'd8,  4'd0,  1'b0);   // -8 / -1 -> -8 r 0
        run_op(4'd10, 4'd0,  4'd15, 4'd10, 1'b1);   // -6 / 0  -> -1 r -6
        run_op(4'd7,  4'd3,  4'd2,  4'd1,  1'b0);
`else
        run_op(4'd13, 4'd3,  4'd4,  4'd1,  1'b0);
        run_op(4'd7,  4'd0,  4'd15, 4'd7,  1'b1);
        run_op(4'd15, 4'd1,  4'd15, 4'd0,  1'b0);
        run_op(4'd2,  4'd9,  4'd0,  4'd2,  1'b0);
        run_op(4'd0,  4'd5,  4'd0,  4'd0,  1'b0);
        run_op(4'd15, 4'd15, 4'd1,  4'd0,  1'b0);

        // start with new operands at N+2 is ignored; result stays 13/3
        sb.push_back('{q: 4'd4, r: 4'd1, dz: 1'b0});
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd13; bus.divisor = 4'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd9; bus.divisor = 4'd2;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.dividend = 4'd0; bus.divisor = 4'd0;
        wait_done(2, W + 1, "latency_ignored_start");
        repeat (8) @(negedge clk);
`endif

        // start held high: second op accepted in the done cycle
        sb.push_back('{q: 4'd3, r: 4'd0, dz: 1'b0});
        sb.push_back('{q: 4'd2, r: 4'd1, dz: 1'b0});
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd6; bus.divisor = 4'd2;
        @(posedge clk);
        @(negedge clk);
        wait_done(0, W + 1, "latency_b2b_first");
        bus.dividend = 4'd7; bus.divisor = 4'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_b2b_second", 32'(bus.busy), 32'd1);
        wait_done(0, W + 1, "latency_b2b_second");
        @(negedge clk);
        chk("busy_after_done", 32'(bus.busy), 32'd0);

        // reset mid-CALC aborts with no done
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd7; bus.divisor = 4'd2;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_quotient",  32'(bus.quotient),    32'd0);
        chk("abort_remainder", 32'(bus.remainder),   32'd0);
        chk("abort_busy",      32'(bus.busy),        32'd0);
        chk("abort_done",      32'(bus.done),        32'd0);
        chk("abort_dz",        32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        run_op(4'd6, 4'd4, 4'd1, 4'd2, 1'b0);

`ifndef SEQ_DIV_SIGNED_EN
        run_op(4'd10, 4'd4, 4'd2, 4'd2, 1'b0);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) run_op(W'(a), W'(b), 4'd15, W'(a), 1'b1);
                else        run_op(W'(a), W'(b), W'(a / b), W'(a % b), 1'b0);
            end
        end
`endif

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
